// File: rtl/rsa_pkg.sv
// Shared types and width defaults for the RSA exponent/reduction datapath.
package rsa_pkg;

  localparam int DW = 64;
  localparam int MW = 8;
  localparam int CW = $clog2(DW);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mod_sub_step.sv
// One restoring shift-subtract step: shifts a dividend bit into the partial
// remainder and subtracts the modulus when it fits.
module mod_sub_step import rsa_pkg::*; #(
  parameter int MW = rsa_pkg::MW
) (
  input  logic [MW-1:0] rem,
  input  logic          bit_in,
  input  logic [MW-1:0] m,
  output logic [MW-1:0] rem_next
);

  logic [MW:0] t;
  logic        ge;

  assign t  = {rem, bit_in};
  assign ge = (t >= {1'b0, m});

  // The true difference is always below 2^MW, so an MW-bit subtract of the
  // low bits gives the exact result even when t[MW] is set.
  assign rem_next = ge ? (t[MW-1:0] - m) : t[MW-1:0];

endmodule

// File: rtl/mod_reduce.sv
// Bit-serial restoring modular reduction: result = dividend mod modulus,
// one dividend bit per clock, start/done single-operation handshake.
//
// state | meaning
// IDLE  | waiting for start; zero modulus completes here with err
// RUN   | shifting DW dividend bits through the subtract step
module mod_reduce import rsa_pkg::*; #(
  parameter int DW = rsa_pkg::DW,
  parameter int MW = rsa_pkg::MW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [MW-1:0] modulus,
  output logic [MW-1:0] result,
  output logic          done,
  output logic          busy,
  output logic          err
);

  localparam int CNTW = $clog2(DW);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DW - 1);

  state_t          state;
  logic [DW-1:0]   sr;
  logic [MW-1:0]   m_q;
  logic [MW-1:0]   rem;
  logic [MW-1:0]   rem_next;
  logic [CNTW-1:0] cnt;

  mod_sub_step #(.MW(MW)) u_step (
    .rem      (rem),
    .bit_in   (sr[DW-1]),
    .m        (m_q),
    .rem_next (rem_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sr     <= '0;
      m_q    <= '0;
      rem    <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (modulus == '0) begin
              result <= '0;
              err    <= 1'b1;
              done   <= 1'b1;
            end else begin
              sr    <= dividend;
              m_q   <= modulus;
              rem   <= '0;
              cnt   <= '0;
              err   <= 1'b0;
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem <= rem_next;
          sr  <= {sr[DW-2:0], 1'b0};
          if (cnt == CNT_LAST) begin
            cnt    <= '0;
            result <= rem_next;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_reduce.sv
// Self-checking bench for mod_reduce: directed table, multi-cycle corner
// sequences and randomized operations against a plain-arithmetic model.
module tb_mod_reduce;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] dividend;
  logic [7:0]  modulus;
  logic [7:0]  result;
  logic        done;
  logic        busy;
  logic        err;

  int checks;
  int failures;

  mod_reduce dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (dividend),
    .modulus  (modulus),
    .result   (result),
    .done     (done),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  m;
    logic [7:0]  exp_r;
    logic        exp_e;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One handshake; inputs are scrambled after the accepting edge so the
  // operation must rely on its latched copies.
  task automatic do_op(input logic [63:0] d, input logic [7:0] m,
                       output int lat, output logic [7:0] r, output logic e,
                       output int busy_cnt, output logic done_after);
    @(negedge clk);
    dividend = d;
    modulus  = m;
    start    = 1'b1;
    lat      = 0;
    busy_cnt = 0;
    r        = '0;
    e        = 1'b0;
    done_after = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        start    = 1'b0;
        dividend = ~d;
        modulus  = m + 8'd3;
      end
      if (busy) busy_cnt++;
      if (done) begin
        lat = i;
        r   = result;
        e   = err;
        break;
      end
    end
    @(posedge clk);
    #1;
    done_after = done;
  endtask

  task automatic run_and_check(input string tag, input logic [63:0] d, input logic [7:0] m);
    int          lat;
    int          bc;
    logic [7:0]  r;
    logic        e;
    logic        da;
    logic [7:0]  exp_r;
    logic        exp_e;
    int          exp_lat;
    int          exp_bc;
    if (m == 8'd0) begin
      exp_r = 8'd0; exp_e = 1'b1; exp_lat = 1; exp_bc = 0;
    end else begin
      exp_r = 8'(d % 64'(m)); exp_e = 1'b0; exp_lat = 65; exp_bc = 64;
    end
    do_op(d, m, lat, r, e, bc, da);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_result"}, 64'(r), 64'(exp_r));
    chk({tag, "_err"}, 64'(e), 64'(exp_e));
    chk({tag, "_busy_cycles"}, 64'(bc), 64'(exp_bc));
    chk({tag, "_done_pulse"}, 64'(da), 64'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int         lat;
    int         bc;
    logic [7:0] r;
    logic       e;
    logic       da;
    int         first_done;
    int         second_done;
    int         extra_done;
    logic [7:0] r1;
    logic [7:0] r2;
    logic       saw_done;

    checks   = 0;
    failures = 0;

    vecs[0] = '{d: 64'd243,                  m: 8'd33,  exp_r: 8'd12, exp_e: 1'b0};
    vecs[1] = '{d: 64'hFFFF_FFFF_FFFF_FFFF,  m: 8'd255, exp_r: 8'd0,  exp_e: 1'b0};
    vecs[2] = '{d: 64'd100,                  m: 8'd7,   exp_r: 8'd2,  exp_e: 1'b0};
    vecs[3] = '{d: 64'd5,                    m: 8'd13,  exp_r: 8'd5,  exp_e: 1'b0};
    vecs[4] = '{d: 64'd5,                    m: 8'd1,   exp_r: 8'd0,  exp_e: 1'b0};
    vecs[5] = '{d: 64'd1234,                 m: 8'd0,   exp_r: 8'd0,  exp_e: 1'b1};
    vecs[6] = '{d: 64'd1000,                 m: 8'd97,  exp_r: 8'd30, exp_e: 1'b0};

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    modulus  = '0;
    #12;
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      do_op(vecs[k].d, vecs[k].m, lat, r, e, bc, da);
      chk($sformatf("vec%0d_result", k), 64'(r), 64'(vecs[k].exp_r));
      chk($sformatf("vec%0d_err", k), 64'(e), 64'(vecs[k].exp_e));
      chk($sformatf("vec%0d_latency", k), 64'(lat), vecs[k].exp_e ? 64'd1 : 64'd65);
      chk($sformatf("vec%0d_busy_cycles", k), 64'(bc), vecs[k].exp_e ? 64'd0 : 64'd64);
      chk($sformatf("vec%0d_done_pulse", k), 64'(da), 64'd0);
      if (vecs[k].exp_e) begin
        chk("zero_mod_err_holds", 64'(err), 64'd1);
      end
    end
    chk("err_cleared_by_valid_start", 64'(err), 64'd0);

    // start held high with operands changing every cycle; the start seen in
    // the done cycle launches the second operation
    @(negedge clk);
    start    = 1'b1;
    dividend = 64'd243;
    modulus  = 8'd33;
    first_done  = 0;
    second_done = 0;
    extra_done  = 0;
    r1 = '0;
    r2 = '0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (first_done == 0) begin
          first_done = i; r1 = result;
        end else if (second_done == 0) begin
          second_done = i; r2 = result;
        end else begin
          extra_done++;
        end
      end
      if (second_done != 0) break;
      if (first_done == i) begin
        dividend = 64'd1000;
        modulus  = 8'd97;
      end else if (first_done != 0 && i == first_done + 1) begin
        start    = 1'b0;
        dividend = {$urandom, $urandom};
        modulus  = 8'($urandom_range(1, 255));
      end else begin
        dividend = {$urandom, $urandom};
        modulus  = 8'($urandom_range(0, 255));
      end
    end
    start = 1'b0;
    chk("held_start_first_edge", 64'(first_done), 64'd65);
    chk("held_start_first_result", 64'(r1), 64'd12);
    chk("held_start_second_edge", 64'(second_done), 64'd130);
    chk("held_start_second_result", 64'(r2), 64'd30);
    chk("held_start_extra_done", 64'(extra_done), 64'd0);

    // asynchronous reset in the middle of the run
    @(negedge clk);
    dividend = 64'hDEAD_BEEF_0123_4567;
    modulus  = 8'd201;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 30; i++) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_result", 64'(result), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_done", 64'(done), 64'd0);
    chk("async_rst_err", 64'(err), 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("aborted_op_silent", 64'(saw_done), 64'd0);
    run_and_check("post_reset", 64'd1000, 8'd97);

    for (int n = 0; n < 40; n++) begin
      logic [63:0] d;
      logic [7:0]  m;
      d = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: d = 64'($urandom_range(0, 300));
        1: d = d >> $urandom_range(0, 63);
        default: ;
      endcase
      m = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      run_and_check($sformatf("rand%0d", n), d, m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_reduce.md
Name: mod_reduce

Overview:
- Bit-serial modular reduction stage; computes result = dividend mod modulus by restoring shift-subtract, one dividend bit per clock.
- Sits directly downstream of the repeated-multiply exponent block: consumes its 64-bit power output and 8-bit modulus to produce the RSA cipher/plain word.
- Uses the same start/done single-operation handshake as the exponent block, so the two chain directly (exponent done -> this block's start).

Parameters:
- DW, 64, dividend width in bits; also the iteration count.
- MW, 8, modulus/result width in bits; matches the exponent block's operand width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  DW  value to reduce; sampled with start
- modulus  input  MW  reduction modulus; sampled with start
- result  output  MW  remainder; holds last value until next completion
- done  output  1  one-cycle completion pulse
- busy  output  1  high while in RUN
- err  output  1  high with done when modulus was 0; cleared on next accepted start

Behaviour:
- Reset: rst_n low at any time, including mid-operation, forces state=IDLE; result, done, busy, err, internal shift register, remainder and counter all go to 0. No done is produced for the aborted operation.
- States: IDLE, RUN. No separate DONE state; done is a registered pulse.
- Latency is counted in sampling edges. Edge 1 is the edge that samples start=1.
- IDLE, start=1, modulus!=0, at edge 1:
  - latch dividend into shift register sr, latch modulus into m;
  - rem=0, cnt=0, err=0, busy=1, go RUN.
- IDLE, start=1, modulus==0, at edge 1:
  - result=0, err=1, done=1; stay IDLE.
- IDLE, start=0: hold; done=0.
- RUN, each edge:
  - t = {rem, sr[DW-1]}, MW+1 bits;
  - rem = (t >= m) ? t - m : t, truncated to MW bits;
  - sr = sr << 1; cnt = cnt + 1.
- Last RUN iteration (cnt==DW-1 at the edge, i.e. edge DW+1 = 65):
  - result=new rem, done=1, busy=0, go IDLE.
- done is a single-cycle pulse in every case; it is 0 on the following edge unless a new zero-modulus start completes.
- start while in RUN is ignored, and input changes in RUN do not affect the operation.
- start high in the cycle where done is high: the block is already in IDLE, so the start is accepted normally.
- Width rules:
  - rem < m <= 2^MW-1 always, so t <= 2^(MW+1)-1 and the MW+1-bit compare/subtract never overflows.
  - cnt is $clog2(DW) bits and wraps to 0 on completion.
- modulus==1 yields 0. dividend < modulus yields dividend unchanged.

Decomposition:
- Shared package rsa_pkg:
  - DW and MW defaults;
  - state enum {IDLE, RUN};
  - localparam CW = $clog2(DW).
- One natural sub-module: mod_sub_step, combinational. Inputs rem, incoming bit, m; output next rem. It holds the compare/conditional-subtract so it can be reused by a later pipelined/unrolled variant.

Test Plan:
1. dividend=243 (3^5), modulus=33, start 1 cycle -> done pulses at edge 65, result=12, err=0, busy high edges 1..64.
2. dividend=64'hFFFF_FFFF_FFFF_FFFF, modulus=255 -> result=0. Then dividend=100, modulus=7 -> result=2.
3. dividend=5, modulus=13 -> result=5. Then dividend=5, modulus=1 -> result=0.
4. modulus=0, dividend=1234 -> done and err=1 at edge 1, result=0, busy never high. The next valid start clears err.
5. start held high continuously with changing operands:
   - only the first is accepted; RUN operands are unaffected;
   - the start seen in the done cycle begins the second operation, whose done arrives 65 edges later.
6. rst_n asserted low asynchronously at RUN iteration 30:
   - all outputs 0 immediately, no done;
   - after release, dividend=1000, modulus=97 -> result=30.
